// File: rtl/triangle_write_arbiter.sv
// Sole writer of the two-beat triangle FIFO: merges precalc entries and line-stepper requeues.
// Build option: define TRI_ARB_RR_EN for round-robin between sources (default strict requeue-first).
module triangle_write_arbiter #(
  parameter int unsigned BEAT_W   = 240,
  parameter int unsigned RQ_DEPTH = 2,
  localparam int unsigned CNT_W   = $clog2(RQ_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*BEAT_W-1:0]   new_data,
  input  logic                  new_valid,
  output logic                  new_ready,
  input  logic [2*BEAT_W-1:0]   req_data,
  input  logic                  req_push,
  output logic [BEAT_W-1:0]     fifo_wrdata,
  output logic                  fifo_push,
  input  logic                  fifo_afull,
  output logic [CNT_W-1:0]      rq_count,
  output logic                  rq_overflow,
  output logic                  busy
);

  localparam int unsigned ENTRY_W = 2 * BEAT_W;
  localparam int unsigned PTR_W   = $clog2(RQ_DEPTH);

  typedef enum logic [1:0] {StIdle, StBeatHi, StBeatLo} state_e;

  state_e             state_q;
  logic [ENTRY_W-1:0] rq_mem [RQ_DEPTH];
  logic [PTR_W-1:0]   rq_wr_ptr_q, rq_rd_ptr_q;
  logic [CNT_W-1:0]   rq_cnt_q;
  logic               rq_ovf_q;
  logic [BEAT_W-1:0]  stage_lo_q;

  logic               can_grant, rq_empty, rq_full;
  logic               grant_rq, grant_new, rq_push_ok;
  logic [ENTRY_W-1:0] grant_entry;

`ifdef TRI_ARB_RR_EN
  logic               last_req_q;  // 1: most recent grant went to the requeue buffer
`endif

  always_comb begin
    can_grant = (state_q == StIdle) & ~fifo_afull & ~rst;
    rq_empty  = (rq_cnt_q == '0);
    rq_full   = (rq_cnt_q == CNT_W'(RQ_DEPTH));
`ifdef TRI_ARB_RR_EN
    new_ready = can_grant & (rq_empty | last_req_q);
    grant_new = new_ready & new_valid;
    grant_rq  = can_grant & ~rq_empty & ~grant_new;
`else
    new_ready = can_grant & rq_empty;
    grant_new = new_ready & new_valid;
    grant_rq  = can_grant & ~rq_empty;
`endif
    // A pop on the same edge frees a slot, so a push into a full buffer still lands.
    rq_push_ok  = req_push & (~rq_full | grant_rq);
    grant_entry = grant_rq ? rq_mem[rq_rd_ptr_q] : new_data;
  end

  always_ff @(posedge clk) begin
    if (rq_push_ok) rq_mem[rq_wr_ptr_q] <= req_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_wr_ptr_q <= '0;
      rq_rd_ptr_q <= '0;
      rq_cnt_q    <= '0;
      rq_ovf_q    <= 1'b0;
    end else begin
      if (rq_push_ok) rq_wr_ptr_q <= rq_wr_ptr_q + PTR_W'(1);
      if (grant_rq)   rq_rd_ptr_q <= rq_rd_ptr_q + PTR_W'(1);
      case ({rq_push_ok, grant_rq})
        2'b10:   rq_cnt_q <= rq_cnt_q + CNT_W'(1);
        2'b01:   rq_cnt_q <= rq_cnt_q - CNT_W'(1);
        default: rq_cnt_q <= rq_cnt_q;
      endcase
      if (req_push && !rq_push_ok) rq_ovf_q <= 1'b1;
    end
  end

  // Upper half goes straight to the output register at grant; only the lower half is staged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      fifo_wrdata <= '0;
      stage_lo_q  <= '0;
`ifdef TRI_ARB_RR_EN
      last_req_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_rq || grant_new) begin
            fifo_wrdata <= grant_entry[ENTRY_W-1:BEAT_W];
            stage_lo_q  <= grant_entry[BEAT_W-1:0];
            state_q     <= StBeatHi;
`ifdef TRI_ARB_RR_EN
            last_req_q  <= grant_rq;
`endif
          end
        end
        StBeatHi: begin
          fifo_wrdata <= stage_lo_q;
          state_q     <= StBeatLo;
        end
        StBeatLo: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign fifo_push   = (state_q != StIdle);
  assign busy        = (state_q != StIdle);
  assign rq_count    = rq_cnt_q;
  assign rq_overflow = rq_ovf_q;

endmodule

// File: tb/tb_triangle_write_arbiter.sv
// Directed + random bench for triangle_write_arbiter against a queue-based reference model.
module tb_triangle_write_arbiter;

  localparam int unsigned BEAT_W   = 240;
  localparam int unsigned RQ_DEPTH = 2;
  localparam int unsigned ENTRY_W  = 2 * BEAT_W;
  localparam int unsigned CNT_W    = $clog2(RQ_DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [ENTRY_W-1:0] new_data = '0;
  logic               new_valid = 1'b0;
  logic               new_ready;
  logic [ENTRY_W-1:0] req_data = '0;
  logic               req_push = 1'b0;
  logic [BEAT_W-1:0]  fifo_wrdata;
  logic               fifo_push;
  logic               fifo_afull = 1'b0;
  logic [CNT_W-1:0]   rq_count;
  logic               rq_overflow;
  logic               busy;

  triangle_write_arbiter #(.BEAT_W(BEAT_W), .RQ_DEPTH(RQ_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .new_data    (new_data),
    .new_valid   (new_valid),
    .new_ready   (new_ready),
    .req_data    (req_data),
    .req_push    (req_push),
    .fifo_wrdata (fifo_wrdata),
    .fifo_push   (fifo_push),
    .fifo_afull  (fifo_afull),
    .rq_count    (rq_count),
    .rq_overflow (rq_overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending requeues, expected beat stream, beats left for the entry in flight.
  logic [ENTRY_W-1:0] m_rq[$];
  logic [BEAT_W-1:0]  m_beats[$];
  logic [BEAT_W-1:0]  obs_hi[$];
  int                 m_rem;
  logic               m_ovf;
  logic [BEAT_W-1:0]  m_last;
  bit                 m_last_req;
  int                 total = 0;
  int                 bad = 0;

  task automatic check(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rq.delete();
    m_beats.delete();
    m_rem      = 0;
    m_ovf      = 1'b0;
    m_last     = '0;
    m_last_req = 1'b0;
  endtask

  function automatic logic [ENTRY_W-1:0] mk(input int h);
    return {BEAT_W'(h), BEAT_W'(h + 1)};
  endfunction

  function automatic logic [ENTRY_W-1:0] rand_entry();
    logic [ENTRY_W-1:0] r;
    for (int i = 0; i < ENTRY_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: check outputs at negedge, advance the model by the spec rules, return after edge.
  task automatic tick(output bit hs);
    bit                 rdy, g_rq, g_new;
    logic [BEAT_W-1:0]  exp_data;
    logic [ENTRY_W-1:0] e;
    @(negedge clk);
    hs  = new_ready && new_valid;
    rdy = !rst && m_rem == 0 && !fifo_afull && m_rq.size() == 0;
`ifdef TRI_ARB_RR_EN
    rdy = !rst && m_rem == 0 && !fifo_afull && (m_rq.size() == 0 || m_last_req);
`endif
    exp_data = m_last;
    if (m_rem > 0) exp_data = m_beats[0];
    check("new_ready", ENTRY_W'(new_ready), ENTRY_W'(rdy));
    check("fifo_push", ENTRY_W'(fifo_push), ENTRY_W'(m_rem > 0));
    check("busy", ENTRY_W'(busy), ENTRY_W'(m_rem > 0));
    check("fifo_wrdata", ENTRY_W'(fifo_wrdata), ENTRY_W'(exp_data));
    check("rq_count", ENTRY_W'(rq_count), ENTRY_W'(m_rq.size()));
    check("rq_overflow", ENTRY_W'(rq_overflow), ENTRY_W'(m_ovf));
    if (m_rem == 2) obs_hi.push_back(fifo_wrdata);
    if (rst) model_reset();
    else begin
      g_rq  = 1'b0;
      g_new = 1'b0;
      if (m_rem > 0) begin
        m_last = m_beats.pop_front();
        m_rem--;
      end else if (!fifo_afull) begin
        if (m_rq.size() > 0 && new_valid) begin
`ifdef TRI_ARB_RR_EN
          if (m_last_req) g_new = 1'b1;
          else g_rq = 1'b1;
`else
          g_rq = 1'b1;
`endif
        end else if (m_rq.size() > 0) g_rq = 1'b1;
        else if (new_valid) g_new = 1'b1;
      end
      if (g_rq || g_new) begin
        if (g_rq) e = m_rq.pop_front();
        else e = new_data;
        m_beats.push_back(e[ENTRY_W-1:BEAT_W]);
        m_beats.push_back(e[BEAT_W-1:0]);
        m_rem      = 2;
        m_last_req = g_rq;
      end
      if (req_push) begin
        if (m_rq.size() < RQ_DEPTH) m_rq.push_back(req_data);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    bit hs;
    for (int i = 0; i < n; i++) tick(hs);
  endtask

  initial begin
    bit hs;
    int n;
    int seq_strict[6];
    int seq_rr[6];
    seq_strict = '{'h11, 'h21, 'h31, 'h51, 'h61, 'h71};
    seq_rr     = '{'h11, 'h51, 'h21, 'h61, 'h31, 'h71};
    model_reset();

    // Power-on reset
    #1 rst = 1'b1;
    #2;
    check("rst_push", ENTRY_W'(fifo_push), '0);
    check("rst_ready", ENTRY_W'(new_ready), '0);
    check("rst_busy", ENTRY_W'(busy), '0);
    check("rst_count", ENTRY_W'(rq_count), '0);
    check("rst_ovf", ENTRY_W'(rq_overflow), '0);
    check("rst_wrdata", ENTRY_W'(fifo_wrdata), '0);
    run(2);
    rst = 1'b0;
    run(1);

    // T2: single new entry, upper beat then lower beat
    new_valid = 1'b1;
    new_data  = {BEAT_W'('hA), BEAT_W'('hB)};
    tick(hs);
    check("t2_hs", ENTRY_W'(hs), ENTRY_W'(1));
    new_valid = 1'b0;
    check("t2_hi", ENTRY_W'(fifo_wrdata), ENTRY_W'(BEAT_W'('hA)));
    check("t2_hi_push", ENTRY_W'(fifo_push), ENTRY_W'(1));
    check("t2_hi_ready", ENTRY_W'(new_ready), '0);
    tick(hs);
    check("t2_lo", ENTRY_W'(fifo_wrdata), ENTRY_W'(BEAT_W'('hB)));
    check("t2_lo_ready", ENTRY_W'(new_ready), '0);
    tick(hs);
    check("t2_idle_push", ENTRY_W'(fifo_push), '0);
    check("t2_idle_hold", ENTRY_W'(fifo_wrdata), ENTRY_W'(BEAT_W'('hB)));
    check("t2_idle_ready", ENTRY_W'(new_ready), ENTRY_W'(1));

    // T3: requeue and new arrive together while busy; requeue goes first, new 3 cycles later
    new_valid = 1'b1;
    new_data  = mk('hE1);
    tick(hs);
    check("t3_n0_hs", ENTRY_W'(hs), ENTRY_W'(1));
    new_data = mk('hF1);
    req_push = 1'b1;
    req_data = {BEAT_W'('hC), BEAT_W'('hD)};
    tick(hs);
    req_push = 1'b0;
    tick(hs);
    tick(hs);
    check("t3_new_waits", ENTRY_W'(hs), '0);
    check("t3_req_first", ENTRY_W'(fifo_wrdata), ENTRY_W'(BEAT_W'('hC)));
    tick(hs);
    tick(hs);
    tick(hs);
    check("t3_new_at_g3", ENTRY_W'(hs), ENTRY_W'(1));
    new_valid = 1'b0;
    check("t3_new_hi", ENTRY_W'(fifo_wrdata), ENTRY_W'(BEAT_W'('hF1)));
    run(3);

    // T5: push into full buffer on the same edge as a pop
    fifo_afull = 1'b1;
    req_push   = 1'b1;
    req_data   = mk('hB1);
    tick(hs);
    req_data = mk('hC1);
    tick(hs);
    req_push = 1'b0;
    tick(hs);
    check("t5_full", ENTRY_W'(rq_count), ENTRY_W'(2));
    obs_hi.delete();
    fifo_afull = 1'b0;
    req_push   = 1'b1;
    req_data   = mk('hD1);
    tick(hs);
    req_push = 1'b0;
    check("t5_count", ENTRY_W'(rq_count), ENTRY_W'(2));
    check("t5_no_ovf", ENTRY_W'(rq_overflow), '0);
    run(10);
    check("t5_n", ENTRY_W'(obs_hi.size()), ENTRY_W'(3));
    if (obs_hi.size() == 3) begin
      check("t5_e0", ENTRY_W'(obs_hi[0]), ENTRY_W'(BEAT_W'('hB1)));
      check("t5_e1", ENTRY_W'(obs_hi[1]), ENTRY_W'(BEAT_W'('hC1)));
      check("t5_e2", ENTRY_W'(obs_hi[2]), ENTRY_W'(BEAT_W'('hD1)));
    end

    // T4: three requeues while FIFO almost full; third is dropped
    fifo_afull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_push = 1'b1;
      req_data = mk('h81 + 16 * k);
      tick(hs);
      req_push = 1'b0;
      run(7);
    end
    check("t4_count", ENTRY_W'(rq_count), ENTRY_W'(2));
    check("t4_ovf", ENTRY_W'(rq_overflow), ENTRY_W'(1));
    check("t4_no_push", ENTRY_W'(fifo_push), '0);
    obs_hi.delete();
    fifo_afull = 1'b0;
    run(8);
    check("t4_n", ENTRY_W'(obs_hi.size()), ENTRY_W'(2));
    if (obs_hi.size() == 2) begin
      check("t4_e0", ENTRY_W'(obs_hi[0]), ENTRY_W'(BEAT_W'('h81)));
      check("t4_e1", ENTRY_W'(obs_hi[1]), ENTRY_W'(BEAT_W'('h91)));
    end

    // T1: asynchronous reset in the middle of an upper beat
    fifo_afull = 1'b1;
    req_push   = 1'b1;
    req_data   = mk('h41);
    tick(hs);
    req_data = mk('h43);
    tick(hs);
    req_push   = 1'b0;
    fifo_afull = 1'b0;
    tick(hs);
    check("t1_busy", ENTRY_W'(busy), ENTRY_W'(1));
    check("t1_count", ENTRY_W'(rq_count), ENTRY_W'(1));
    #2 rst = 1'b1;
    #1;
    check("t1_push", ENTRY_W'(fifo_push), '0);
    check("t1_count0", ENTRY_W'(rq_count), '0);
    check("t1_idle", ENTRY_W'(busy), '0);
    check("t1_ovf0", ENTRY_W'(rq_overflow), '0);
    model_reset();
    tick(hs);
    rst = 1'b0;

    // T6: both sources kept pending; order depends on arbitration mode
    fifo_afull = 1'b1;
    req_push   = 1'b1;
    req_data   = mk('h11);
    tick(hs);
    req_data = mk('h21);
    tick(hs);
    req_push = 1'b0;
    obs_hi.delete();
    n          = 0;
    new_valid  = 1'b1;
    new_data   = mk('h51);
    fifo_afull = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req_push = (i == 1);
      req_data = mk('h31);
      tick(hs);
      if (hs) begin
        n++;
        if (n < 3) new_data = mk('h51 + 16 * n);
        else new_valid = 1'b0;
      end
    end
    req_push = 1'b0;
    check("t6_n", ENTRY_W'(obs_hi.size()), ENTRY_W'(6));
    for (int i = 0; i < 6 && i < obs_hi.size(); i++) begin
`ifdef TRI_ARB_RR_EN
      check($sformatf("t6_rr_%0d", i), ENTRY_W'(obs_hi[i]), ENTRY_W'(BEAT_W'(seq_rr[i])));
`else
      check($sformatf("t6_strict_%0d", i), ENTRY_W'(obs_hi[i]), ENTRY_W'(BEAT_W'(seq_strict[i])));
`endif
    end
    run(4);

    // Random traffic; new_data held stable until its handshake
    new_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      fifo_afull = ($urandom_range(3) == 0);
      req_push   = ($urandom_range(4) == 0);
      req_data   = rand_entry();
      if (!new_valid) begin
        new_valid = ($urandom_range(1) == 0);
        new_data  = rand_entry();
      end
      tick(hs);
      if (hs) new_valid = 1'b0;
    end
    req_push   = 1'b0;
    new_valid  = 1'b0;
    fifo_afull = 1'b0;
    run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
